proc_fl: RTL and testbench

- Functional-level (FL) TinyRV1 processor: executes exactly one instruction per clock edge against an internal unified instruction/data memory array `M`.
- Exposes three 32-bit input ports and three 32-bit output ports, both accessed through CSRs.
- Emits a per-instruction retirement trace used by the ISA test suites (add, addi, mul, lw, sw, jal, jr, bne, csr).
- Serves as the golden reference that the pipelined and multicycle processors are compared against.

---
 rtl/proc_fl.sv | 187 ++++++++++++++++++
 tb/tb_proc_fl.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/proc_fl.sv
// proc_fl: functional-level TinyRV1 processor. Executes one instruction per
// rising clock edge against a unified instruction/data memory M, exposes three
// CSR-mapped input and output ports, and registers a per-instruction retirement
// trace.
module proc_fl #(
   parameter int unsigned MEM_BYTES = 'h10000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] in0,
   input  logic [31:0] in1,
   input  logic [31:0] in2,
   output logic [31:0] out0,
   output logic [31:0] out1,
   output logic [31:0] out2,
   output logic        trace_val,
   output logic [31:0] trace_addr,
   output logic [31:0] trace_inst,
   output logic [31:0] trace_data
);

   localparam int unsigned AW = $clog2(MEM_BYTES);

   typedef enum logic [6:0] {
      OP_REG    = 7'b0110011,
      OP_IMM    = 7'b0010011,
      OP_LOAD   = 7'b0000011,
      OP_STORE  = 7'b0100011,
      OP_JAL    = 7'b1101111,
      OP_JALR   = 7'b1100111,
      OP_BRANCH = 7'b1100011,
      OP_SYSTEM = 7'b1110011
   } opcode_e;

   // Word entries indexed by byte address; only word-aligned entries are used.
   logic [31:0] M [MEM_BYTES];

   logic [31:0] pc_q, pc_d;
   logic [31:0] rf_q [32];
   logic [31:0] out0_q, out0_d, out1_q, out1_d, out2_q, out2_d;
   logic        trace_val_q, trace_val_d;
   logic [31:0] trace_addr_q, trace_addr_d;
   logic [31:0] trace_inst_q, trace_inst_d;
   logic [31:0] trace_data_q, trace_data_d;

   logic [AW-1:0] fetch_idx, mem_idx;
   logic [31:0]   inst, rs1_v, rs2_v, mem_ea;
   logic [31:0]   imm_i, imm_s, imm_b, imm_j;
   logic [6:0]    opcode, funct7;
   logic [4:0]    rd, rs1, rs2;
   logic [2:0]    funct3;
   logic [11:0]   csr;
   logic          wb_en, mem_we;
   logic [31:0]   wb_val;

   // Addresses wrap modulo the memory size and are forced to word alignment.
   assign fetch_idx = AW'((pc_q % MEM_BYTES) & ~32'd3);
   assign inst      = M[fetch_idx];

   assign opcode = inst[6:0];
   assign rd     = inst[11:7];
   assign funct3 = inst[14:12];
   assign rs1    = inst[19:15];
   assign rs2    = inst[24:20];
   assign funct7 = inst[31:25];
   assign csr    = inst[31:20];

   assign imm_i = {{20{inst[31]}}, inst[31:20]};
   assign imm_s = {{20{inst[31]}}, inst[31:25], inst[11:7]};
   assign imm_b = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
   assign imm_j = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};

   assign rs1_v = (rs1 == 5'd0) ? '0 : rf_q[rs1];
   assign rs2_v = (rs2 == 5'd0) ? '0 : rf_q[rs2];

   assign mem_ea  = rs1_v + ((opcode == OP_STORE) ? imm_s : imm_i);
   assign mem_idx = AW'((mem_ea % MEM_BYTES) & ~32'd3);

   // Decode and execute the fetched instruction; unrecognised encodings fall through as nops.
   always_comb begin
      pc_d   = pc_q + 32'd4;
      wb_en  = 1'b0;
      wb_val = '0;
      mem_we = 1'b0;
      out0_d = out0_q;
      out1_d = out1_q;
      out2_d = out2_q;
      case (opcode)
         OP_REG: begin
            if (funct3 == 3'b000 && funct7 == 7'b0000000) begin
               wb_en  = 1'b1;
               wb_val = rs1_v + rs2_v;
            end else if (funct3 == 3'b000 && funct7 == 7'b0000001) begin
               wb_en  = 1'b1;
               wb_val = rs1_v * rs2_v;
            end
         end
         OP_IMM: begin
            if (funct3 == 3'b000) begin
               wb_en  = 1'b1;
               wb_val = rs1_v + imm_i;
            end
         end
         OP_LOAD: begin
            if (funct3 == 3'b010) begin
               wb_en  = 1'b1;
               wb_val = M[mem_idx];
            end
         end
         OP_STORE: begin
            if (funct3 == 3'b010) mem_we = 1'b1;
         end
         OP_JAL: begin
            wb_en  = 1'b1;
            wb_val = pc_q + 32'd4;
            pc_d   = pc_q + imm_j;
         end
         OP_JALR: begin
            if (rd == 5'd0 && funct3 == 3'b000 && csr == 12'd0) pc_d = rs1_v;
         end
         OP_BRANCH: begin
            if (funct3 == 3'b001 && rs1_v != rs2_v) pc_d = pc_q + imm_b;
         end
         OP_SYSTEM: begin
            if (funct3 == 3'b010 && rs1 == 5'd0) begin
               case (csr)
                  12'hFC0: begin wb_en = 1'b1; wb_val = in0; end
                  12'hFC1: begin wb_en = 1'b1; wb_val = in1; end
                  12'hFC2: begin wb_en = 1'b1; wb_val = in2; end
                  default: ;
               endcase
            end else if (funct3 == 3'b001 && rd == 5'd0) begin
               case (csr)
                  12'h7C0: out0_d = rs1_v;
                  12'h7C1: out1_d = rs1_v;
                  12'h7C2: out2_d = rs1_v;
                  default: ;
               endcase
            end
         end
         default: ;
      endcase
      trace_val_d  = 1'b1;
      trace_addr_d = pc_q;
      trace_inst_d = inst;
      trace_data_d = wb_en ? wb_val : 'x;
   end

   // Architectural state and trace registers; x0 is never written.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pc_q <= '0;
         for (int unsigned i = 0; i < 32; i++) rf_q[i[4:0]] <= '0;
         out0_q       <= '0;
         out1_q       <= '0;
         out2_q       <= '0;
         trace_val_q  <= 1'b0;
         trace_addr_q <= '0;
         trace_inst_q <= '0;
         trace_data_q <= '0;
      end else begin
         pc_q <= pc_d;
         if (wb_en && rd != 5'd0) rf_q[rd] <= wb_val;
         out0_q       <= out0_d;
         out1_q       <= out1_d;
         out2_q       <= out2_d;
         trace_val_q  <= trace_val_d;
         trace_addr_q <= trace_addr_d;
         trace_inst_q <= trace_inst_d;
         trace_data_q <= trace_data_d;
      end
   end

   // Store port; memory contents survive reset.
   always_ff @(posedge clk) begin
      if (rst && mem_we) M[mem_idx] <= rs2_v;
   end

   assign out0       = out0_q;
   assign out1       = out1_q;
   assign out2       = out2_q;
   assign trace_val  = trace_val_q;
   assign trace_addr = trace_addr_q;
   assign trace_inst = trace_inst_q;
   assign trace_data = trace_data_q;

endmodule

// File: tb/tb_proc_fl.sv
// tb_proc_fl: directed table of TinyRV1 instructions with hand-derived trace
// values, mid-run reset sequence, and random programs checked against an
// instruction-level reference model.
module tb_proc_fl;

   logic        clk;
   logic        rst;
   logic [31:0] in0, in1, in2;
   logic [31:0] out0, out1, out2;
   logic        trace_val;
   logic [31:0] trace_addr, trace_inst, trace_data;

   int n_vec = 0;
   int n_err = 0;

   proc_fl #(.MEM_BYTES('h10000)) dut (
      .clk        (clk),
      .rst        (rst),
      .in0        (in0),
      .in1        (in1),
      .in2        (in2),
      .out0       (out0),
      .out1       (out1),
      .out2       (out2),
      .trace_val  (trace_val),
      .trace_addr (trace_addr),
      .trace_inst (trace_inst),
      .trace_data (trace_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete, got timeout required finish");
      $fatal(1);
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %08h required %08h", nm, act, exp);
      end
   endtask

   // ---------------- instruction encoders ----------------
   function automatic logic [31:0] i_t(input int imm, input int rs1, input int f3, input int rd, input int op);
      return {12'(imm), 5'(rs1), 3'(f3), 5'(rd), 7'(op)};
   endfunction
   function automatic logic [31:0] r_t(input int f7, input int rs2, input int rs1, input int rd);
      return {7'(f7), 5'(rs2), 5'(rs1), 3'b000, 5'(rd), 7'h33};
   endfunction
   function automatic logic [31:0] s_t(input int imm, input int rs2, input int rs1);
      logic [31:0] v;
      v = 32'(imm);
      return {v[11:5], 5'(rs2), 5'(rs1), 3'b010, v[4:0], 7'h23};
   endfunction
   function automatic logic [31:0] b_t(input int imm, input int rs1, input int rs2);
      logic [31:0] v;
      v = 32'(imm);
      return {v[12], v[10:5], 5'(rs2), 5'(rs1), 3'b001, v[4:1], v[11], 7'h63};
   endfunction
   function automatic logic [31:0] j_t(input int imm, input int rd);
      logic [31:0] v;
      v = 32'(imm);
      return {v[20], v[10:1], v[11], v[19:12], 5'(rd), 7'h6F};
   endfunction
   function automatic logic [31:0] jr_t(input int rs1);
      return {12'd0, 5'(rs1), 3'b000, 5'd0, 7'h67};
   endfunction
   function automatic logic [31:0] csrr_t(input int rd, input int csr);
      return {12'(csr), 5'd0, 3'b010, 5'(rd), 7'h73};
   endfunction
   function automatic logic [31:0] csrw_t(input int csr, input int rs1);
      return {12'(csr), 5'(rs1), 3'b001, 5'd0, 7'h73};
   endfunction

   // ---------------- reference model ----------------
   logic [31:0] mreg [32];
   logic [31:0] mmem [int unsigned];
   logic [31:0] mpc;
   logic [31:0] mout [3];

   function automatic int unsigned widx(input logic [31:0] ea);
      return (ea % 32'h10000) & 32'hFFFF_FFFC;
   endfunction

   task automatic put(input int unsigned a, input logic [31:0] v);
      dut.M[16'(a)] = v;
      mmem[a] = v;
   endtask

   task automatic model_reset();
      for (int i = 0; i < 32; i++) mreg[i] = '0;
      for (int i = 0; i < 3; i++) mout[i] = '0;
      mpc = '0;
   endtask

   task automatic model_step(output logic [31:0] e_addr, output logic [31:0] e_inst,
                             output bit e_has, output logic [31:0] e_data);
      logic [31:0] inst, a, b, npc, data;
      logic [11:0] csr;
      int si, imm_i, imm_s, imm_b, imm_j, rd, rs1, rs2, f3, f7, op;
      bit has;
      inst  = mmem[widx(mpc)];
      op    = int'(inst[6:0]);
      rd    = int'(inst[11:7]);
      f3    = int'(inst[14:12]);
      rs1   = int'(inst[19:15]);
      rs2   = int'(inst[24:20]);
      f7    = int'(inst[31:25]);
      csr   = inst[31:20];
      si    = int'(inst);
      imm_i = si >>> 20;
      imm_s = (si >>> 25) * 32 + int'(inst[11:7]);
      imm_b = (si >>> 31) * 4096 + int'(inst[7]) * 2048 + int'(inst[30:25]) * 32 + int'(inst[11:8]) * 2;
      imm_j = (si >>> 31) * 1048576 + int'(inst[19:12]) * 4096 + int'(inst[20]) * 2048 + int'(inst[30:21]) * 2;
      a     = mreg[rs1];
      b     = mreg[rs2];
      npc   = mpc + 32'd4;
      has   = 1'b0;
      data  = '0;
      case (op)
         'h33: if (f3 == 0 && f7 == 0) begin has = 1; data = a + b; end
               else if (f3 == 0 && f7 == 1) begin has = 1; data = 32'(64'(a) * 64'(b)); end
         'h13: if (f3 == 0) begin has = 1; data = a + 32'(imm_i); end
         'h03: if (f3 == 2) begin has = 1; data = mmem[widx(a + 32'(imm_i))]; end
         'h23: if (f3 == 2) mmem[widx(a + 32'(imm_s))] = b;
         'h6F: begin has = 1; data = mpc + 32'd4; npc = mpc + 32'(imm_j); end
         'h67: if (rd == 0 && f3 == 0 && imm_i == 0) npc = a;
         'h63: if (f3 == 1 && a != b) npc = mpc + 32'(imm_b);
         'h73: begin
            if (f3 == 2 && rs1 == 0 && csr >= 12'hFC0 && csr <= 12'hFC2) begin
               has  = 1;
               data = (csr == 12'hFC0) ? in0 : (csr == 12'hFC1) ? in1 : in2;
            end else if (f3 == 1 && rd == 0 && csr >= 12'h7C0 && csr <= 12'h7C2) begin
               mout[int'(csr - 12'h7C0)] = a;
            end
         end
         default: ;
      endcase
      if (has && rd != 0) mreg[rd] = data;
      e_addr = mpc;
      e_inst = inst;
      e_has  = has;
      e_data = data;
      mpc    = npc;
   endtask

   // ---------------- random program generation ----------------
   function automatic int rreg();
      return int'($urandom_range(0, 7));
   endfunction
   function automatic int dimm();
      if ($urandom_range(0, 1) == 1) return int'($urandom_range(1024, 1279));
      return -int'($urandom_range(1, 256));
   endfunction
   function automatic logic [31:0] rand_inst();
      logic [31:0] r;
      r = $urandom();
      case ($urandom_range(0, 11))
         0, 11: return i_t(int'($urandom_range(0, 4095)) - 2048, rreg(), 0, rreg(), 'h13);
         1:     return r_t(0, rreg(), rreg(), rreg());
         2:     return r_t(1, rreg(), rreg(), rreg());
         3:     return i_t(dimm(), 0, 2, rreg(), 'h03);
         4:     return s_t(dimm(), rreg(), 0);
         5:     return b_t(4 * int'($urandom_range(1, 4)), rreg(), rreg());
         6:     return j_t(4 * int'($urandom_range(1, 4)), rreg());
         7:     return csrr_t(rreg(), 'hFC0 + int'($urandom_range(0, 3)));
         8:     return csrw_t('h7C0 + int'($urandom_range(0, 3)), rreg());
         9:     return {r[31:7], 7'h0B};
         default: return r_t(2, rreg(), rreg(), rreg());
      endcase
   endfunction

   task automatic run_random(input int prog);
      logic [31:0] ea, ei, ed;
      bit eh;
      rst = 1'b0;
      #1;
      mmem.delete();
      for (int unsigned a = 0; a < 'h400; a += 4) put(a, rand_inst());
      for (int unsigned a = 'h400; a < 'h500; a += 4) put(a, $urandom());
      for (int unsigned a = 'hFF00; a < 'h10000; a += 4) put(a, $urandom());
      model_reset();
      in0 = $urandom();
      in1 = $urandom();
      in2 = $urandom();
      @(negedge clk) rst = 1'b1;
      for (int c = 0; c < 60; c++) begin
         model_step(ea, ei, eh, ed);
         @(posedge clk);
         #1;
         chk($sformatf("p%0d c%0d trace_val", prog, c), {31'd0, trace_val}, 32'd1);
         chk($sformatf("p%0d c%0d trace_addr", prog, c), trace_addr, ea);
         chk($sformatf("p%0d c%0d trace_inst", prog, c), trace_inst, ei);
         if (eh) chk($sformatf("p%0d c%0d trace_data", prog, c), trace_data, ed);
         chk($sformatf("p%0d c%0d out0", prog, c), out0, mout[0]);
         chk($sformatf("p%0d c%0d out1", prog, c), out1, mout[1]);
         chk($sformatf("p%0d c%0d out2", prog, c), out2, mout[2]);
      end
   endtask

   // ---------------- directed table ----------------
   typedef struct {
      logic [31:0] pc;
      logic [31:0] inst;
      bit          has;
      logic [31:0] data;
   } vec_t;

   vec_t tab[$];

   initial begin
      // Listed in execution order; pc is where the instruction lives and the expected trace address.
      tab.push_back('{32'h00, i_t(2, 0, 0, 1, 'h13),   1'b1, 32'h0000_0002});
      tab.push_back('{32'h04, i_t(3, 0, 0, 2, 'h13),   1'b1, 32'h0000_0003});
      tab.push_back('{32'h08, r_t(0, 2, 1, 3),         1'b1, 32'h0000_0005});
      tab.push_back('{32'h0C, b_t(8, 1, 0),            1'b0, 32'h0});
      tab.push_back('{32'h14, j_t(8, 5),               1'b1, 32'h0000_0018});
      tab.push_back('{32'h1C, jr_t(5),                 1'b0, 32'h0});
      tab.push_back('{32'h18, j_t(12, 0),              1'b1, 32'h0000_001C});
      tab.push_back('{32'h24, i_t(-1, 0, 0, 1, 'h13),  1'b1, 32'hFFFF_FFFF});
      tab.push_back('{32'h28, i_t(1, 0, 0, 2, 'h13),   1'b1, 32'h0000_0001});
      tab.push_back('{32'h2C, r_t(0, 2, 1, 3),         1'b1, 32'h0000_0000});
      tab.push_back('{32'h30, r_t(0, 1, 1, 0),         1'b1, 32'hFFFF_FFFE});
      tab.push_back('{32'h34, r_t(0, 0, 0, 4),         1'b1, 32'h0000_0000});
      tab.push_back('{32'h38, i_t(7, 0, 0, 1, 'h13),   1'b1, 32'h0000_0007});
      tab.push_back('{32'h3C, r_t(0, 1, 1, 1),         1'b1, 32'h0000_000E});
      tab.push_back('{32'h40, i_t('h100, 0, 2, 1, 3),  1'b1, 32'h0000_002A});
      tab.push_back('{32'h44, r_t(1, 1, 1, 2),         1'b1, 32'h0000_06E4});
      tab.push_back('{32'h48, s_t('h104, 2, 0),        1'b0, 32'h0});
      tab.push_back('{32'h4C, i_t('h104, 0, 2, 7, 3),  1'b1, 32'h0000_06E4});
      tab.push_back('{32'h50, csrr_t(1, 'hFC0),        1'b1, 32'h1234_5678});
      tab.push_back('{32'h54, csrw_t('h7C1, 1),        1'b0, 32'h0});
      tab.push_back('{32'h58, 32'h0000_007F,           1'b0, 32'h0});
      tab.push_back('{32'h5C, csrr_t(2, 'hFC5),        1'b0, 32'h0});
      tab.push_back('{32'h60, i_t('h103, 0, 2, 9, 3),  1'b1, 32'h0000_002A});
      tab.push_back('{32'h64, i_t(-4, 0, 2, 10, 3),    1'b1, 32'hCAFE_F00D});
      tab.push_back('{32'h68, r_t(0, 0, 2, 11),        1'b1, 32'h0000_06E4});

      rst = 1'b1;
      in0 = 32'h1234_5678;
      in1 = '0;
      in2 = '0;
      #2 rst = 1'b0;
      #1;
      chk("reset trace_val", {31'd0, trace_val}, 32'd0);
      chk("reset trace_addr", trace_addr, 32'd0);
      chk("reset trace_inst", trace_inst, 32'd0);
      chk("reset trace_data", trace_data, 32'd0);
      chk("reset out0", out0, 32'd0);
      chk("reset out1", out1, 32'd0);
      chk("reset out2", out2, 32'd0);

      for (int k = 0; k < tab.size(); k++) dut.M[16'(tab[k].pc)] = tab[k].inst;
      dut.M[16'h0010] = i_t(99, 0, 0, 9, 'h13);
      dut.M[16'h0020] = i_t(77, 0, 0, 9, 'h13);
      dut.M[16'h0100] = 32'h0000_002A;
      dut.M[16'h0104] = 32'h0000_0000;
      dut.M[16'hFFFC] = 32'hCAFE_F00D;

      @(negedge clk) rst = 1'b1;
      for (int k = 0; k < tab.size(); k++) begin
         @(posedge clk);
         #1;
         chk($sformatf("tab%0d trace_val", k), {31'd0, trace_val}, 32'd1);
         chk($sformatf("tab%0d trace_addr", k), trace_addr, tab[k].pc);
         chk($sformatf("tab%0d trace_inst", k), trace_inst, tab[k].inst);
         if (tab[k].has) chk($sformatf("tab%0d trace_data", k), trace_data, tab[k].data);
      end
      chk("csrw out1", out1, 32'h1234_5678);
      chk("csrw out0", out0, 32'd0);
      chk("csrw out2", out2, 32'd0);
      chk("sw M[104]", dut.M[16'h0104], 32'h0000_06E4);

      // Asynchronous reset between edges, then restart from PC 0.
      #2 rst = 1'b0;
      #1;
      chk("midreset trace_val", {31'd0, trace_val}, 32'd0);
      chk("midreset trace_addr", trace_addr, 32'd0);
      chk("midreset out1", out1, 32'd0);
      chk("midreset out0", out0, 32'd0);
      @(negedge clk) rst = 1'b1;
      @(posedge clk);
      #1;
      chk("restart trace_val", {31'd0, trace_val}, 32'd1);
      chk("restart trace_addr", trace_addr, 32'd0);
      chk("restart trace_inst", trace_inst, tab[0].inst);
      chk("restart trace_data", trace_data, 32'h0000_0002);

      for (int p = 0; p < 8; p++) run_random(p);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
